// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: default register-file geometry and
// the writeback source encoding used by the EM/WB stage.
package cpu_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 8;

    typedef enum logic {
        WDC_ALU = 1'b0,
        WDC_MEM = 1'b1
    } wdc_e;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback / register-read bundle between the pipeline and wb_regfile.
// The slave side is the register file; the master side is the pipeline.
interface wb_regfile_if #(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
);

    logic              regwrite_i;
    logic              write_data_control_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [DATA_W-1:0] q_i;
    logic [ADDR_W-1:0] write_addr_i;
    logic [ADDR_W-1:0] rs_addr_i;
    logic [ADDR_W-1:0] rt_addr_i;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;
    logic [DATA_W-1:0] wb_data_o;
    logic              hist_valid_o;
    logic [ADDR_W-1:0] hist_addr_o;
    logic [DATA_W-1:0] hist_data_o;

    modport slave (
        input  regwrite_i, write_data_control_i, alu_result_i, q_i,
               write_addr_i, rs_addr_i, rt_addr_i,
        output rs_data_o, rt_data_o, wb_data_o,
               hist_valid_o, hist_addr_o, hist_data_o
    );

    modport master (
        output regwrite_i, write_data_control_i, alu_result_i, q_i,
               write_addr_i, rs_addr_i, rt_addr_i,
        input  rs_data_o, rt_data_o, wb_data_o,
               hist_valid_o, hist_addr_o, hist_data_o
    );

endinterface

// File: rtl/regfile_core.sv
// Register array: one synchronous write port, two raw asynchronous read
// ports, asynchronous active-low clear of every entry.
module regfile_core #(
    parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Register file with writeback source mux, write-first read bypass and a
// one-entry history of the last committed write.
module wb_regfile #(
    parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int unsigned R0_ZERO  = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    wb_regfile_if.slave  bus
);

    import cpu_pkg::*;

    logic              r0_hard;
    logic              commit;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] raw_rs;
    logic [DATA_W-1:0] raw_rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    assign r0_hard = (R0_ZERO != 0);

    always_comb begin
        wb_data = (bus.write_data_control_i == WDC_MEM) ? bus.q_i : bus.alu_result_i;
        commit  = rst_n_i && bus.regwrite_i
                  && !(r0_hard && (bus.write_addr_i == '0));
    end

    regfile_core #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_core (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .we      (commit),
        .waddr   (bus.write_addr_i),
        .wdata   (wb_data),
        .raddr_a (bus.rs_addr_i),
        .raddr_b (bus.rt_addr_i),
        .rdata_a (raw_rs),
        .rdata_b (raw_rt)
    );

    // Bypass keys off commit, so reset and hardwired r0 suppress it for free.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rst_n_i && !(r0_hard && (bus.rs_addr_i == '0))) begin
            rs_data = (commit && (bus.rs_addr_i == bus.write_addr_i)) ? wb_data : raw_rs;
        end
        if (rst_n_i && !(r0_hard && (bus.rt_addr_i == '0))) begin
            rt_data = (commit && (bus.rt_addr_i == bus.write_addr_i)) ? wb_data : raw_rt;
        end
    end

    assign bus.rs_data_o = rs_data;
    assign bus.rt_data_o = rt_data;
    assign bus.wb_data_o = wb_data;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.hist_valid_o <= 1'b0;
            bus.hist_addr_o  <= '0;
            bus.hist_data_o  <= '0;
        end else begin
            bus.hist_valid_o <= commit;
            if (commit) begin
                bus.hist_addr_o <= bus.write_addr_i;
                bus.hist_data_o <= wb_data;
            end
        end
    end

endmodule
